// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants, reused by the fetch queue and later
// by the load/store queue.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INST_W       = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INST_W-1:0]       inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; flush empties it and drops any same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues one-cycle-latency instruction-memory
// reads and buffers {pc, inst} pairs for decode, with redirect and flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4,
  localparam int             CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int SUM_W = CNT_W + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_INC) - XLEN'(1));

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             room;
  logic             issue;
  logic             resp_kill;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  entry_t           push_entry;
  entry_t           head_entry;

  // Space is reserved at issue time, so a response always has a slot waiting.
  always_comb begin
    room          = !fifo_full &&
                    ((SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
    issue         = room && !reset && !redirect_valid;
    resp_kill     = reset || redirect_valid;
    fifo_push     = inflight_q && !resp_kill;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
    end
    if (issue) begin
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc_q;
  assign push_entry = '{pc: inflight_pc_q, inst: imem_rdata};

  // Decode handshake: a transfer happens when inst_valid && inst_ready.
  // inst_valid comes from registered FIFO state only, and the head entry holds
  // still until it is transferred.
  assign inst_valid = !fifo_empty;
  assign fifo_pop   = inst_valid && inst_ready;
  assign inst_data  = head_entry.inst;
  assign inst_pc    = head_entry.pc;
  assign occupancy  = fifo_count;

  sync_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .pop_data (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset-release vector table, hand-written
// fill/redirect/reset sequences and random traffic against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;

  logic        imem_req, imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic [31:0] imem_rdata, imem_rdata_w;
  logic        inst_valid, inst_valid_w;
  logic [31:0] inst_data, inst_data_w;
  logic [31:0] inst_pc, inst_pc_w;
  logic [2:0]  occupancy, occupancy_w;

  always #5 clock = ~clock;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_INC(4)) dut (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .occupancy(occupancy)
  );

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_INC(4)) dut_w (
    .clock(clock), .reset(reset), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .inst_valid(inst_valid_w), .inst_ready(inst_ready),
    .inst_data(inst_data_w), .inst_pc(inst_pc_w), .occupancy(occupancy_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Instruction memory: data one cycle after the request, garbage otherwise.
  always @(posedge clock) begin
    imem_rdata   <= imem_req   ? mem_word(imem_addr)   : 32'hDEAD_BEEF;
    imem_rdata_w <= imem_req_w ? mem_word(imem_addr_w) : 32'hDEAD_BEEF;
  end

  // Scoreboard / reference model: queued PCs, one pending fetch, next PC.
  logic [31:0] exp_q[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_pc;
  bit          m_init = 1'b0;
  logic [31:0] deliv_q[$];
  logic [31:0] req_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic rdy);
    bit exp_req;
    reset = rst;
    redirect_valid = redir;
    redirect_pc = rpc;
    inst_ready = rdy;
    @(negedge clock);
    if (m_init) begin
      exp_req = !rst && !redir && ((exp_q.size() + int'(m_pend)) < DEPTH);
      chk("model_req", imem_req, exp_req);
      if (exp_req) chk("model_addr", imem_addr, m_pc);
      chk("model_valid", inst_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("model_pc", inst_pc, exp_q[0]);
        chk("model_data", inst_data, mem_word(exp_q[0]));
      end
      chk("model_occ", occupancy, exp_q.size());
    end
    if (imem_req) req_q.push_back(imem_addr);
    if (inst_valid && rdy && !rst) deliv_q.push_back(inst_pc);
  endtask

  task automatic adv();
    bit pop_now;
    bit issue_now;
    pop_now   = (exp_q.size() != 0) && inst_ready;
    issue_now = !reset && !redirect_valid && ((exp_q.size() + int'(m_pend)) < DEPTH);
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      m_pend = 1'b0;
      m_pc = 32'h0;
      m_init = 1'b1;
    end else begin
      if (pop_now) void'(exp_q.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        m_pend = 1'b0;
        m_pc = redirect_pc & ~32'h3;
      end else begin
        if (m_pend) exp_q.push_back(m_pend_pc);
        m_pend = issue_now;
        if (issue_now) begin
          m_pend_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    #1;
  endtask

  task automatic cycle(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic rdy);
    drive(rst, redir, rpc, rdy);
    adv();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    req_q.delete();
    deliv_q.delete();
  endtask

  task automatic fill4();
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc_w;
    logic [2:0]  exp_occ;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0,         3'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0,         3'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0,         3'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 32'hFFFF_FFF8, 3'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 32'hFFFF_FFFC, 3'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 32'h0000_0000, 3'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, 32'h0000_0004, 3'd1};

    // Reset release with a consumer that is always ready.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rst, 1'b0, 32'h0, tbl[i].ready);
      chk("t_req", imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk("t_addr", imem_addr, tbl[i].exp_addr);
      chk("t_valid", inst_valid, tbl[i].exp_valid);
      chk("t_valid_w", inst_valid_w, tbl[i].exp_valid);
      chk("t_occ", occupancy, tbl[i].exp_occ);
      if (tbl[i].exp_valid) begin
        chk("t_pc", inst_pc, tbl[i].exp_pc);
        chk("t_data", inst_data, mem_word(tbl[i].exp_pc));
        chk("t_pc_wrap", inst_pc_w, tbl[i].exp_pc_w);
        chk("t_data_wrap", inst_data_w, mem_word(tbl[i].exp_pc_w));
      end
      adv();
    end

    // Stalled consumer: exactly DEPTH requests, then drain in order.
    do_reset();
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_req_count", req_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("stall_req_addr", req_q[i], 32'(4 * i));
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_full_req", imem_req, 1'b0);
    chk("stall_full_occ", occupancy, 3'd4);
    chk("stall_head_pc", inst_pc, 32'h0);
    adv();
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) chk("stall_drain_pc", deliv_q[i], 32'(4 * i));

    // Redirect with three queued entries and one request in flight.
    fill4();
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    chk("redir_pre_occ", occupancy, 3'd3);
    adv();
    deliv_q.delete();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_occ", occupancy, 3'd0);
    chk("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 32'h100);
    adv();
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_first_pc", deliv_q[0], 32'h100);
    chk("redir_second_pc", deliv_q[1], 32'h104);

    // Misaligned redirect coinciding with a handshake.
    fill4();
    drive(1'b0, 1'b1, 32'h103, 1'b1);
    chk("redir_hs_occ", occupancy, 3'd3);
    chk("redir_hs_head", inst_pc, 32'h0);
    adv();
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_hs_taken", deliv_q[0], 32'h0);
    chk("redir_hs_next", deliv_q[1], 32'h100);
    chk("redir_hs_after", deliv_q[2], 32'h104);

    // One-cycle reset mid-stream with all slots reserved.
    fill4();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_pre_occ", occupancy, 3'd3);
    adv();
    deliv_q.delete();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_req", imem_req, 1'b1);
    chk("rst_addr", imem_addr, 32'h0);
    adv();
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_pc0", deliv_q[0], 32'h0);
    chk("rst_pc1", deliv_q[1], 32'h4);
    chk("rst_pc2", deliv_q[2], 32'h8);

    // Random traffic, checked every cycle against the model.
    do_reset();
    repeat (800) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
